// File: rtl/serial_adder.sv
// Bit-serial adder: loads two WIDTH-bit operands, then produces their sum one
// bit per clock (LSB first) through a single full adder and one carry flop.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-1:0] sum_nxt;
  logic [CW-1:0]    cnt;
  logic             c;
  logic [1:0]       fa_out;

  // {carry, sum}
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    logic [1:0] h1, h2;
    h1 = half_add(x, y);
    h2 = half_add(h1[0], cin);
    return {h1[1] | h2[1], h2[0]};
  endfunction

  assign fa_out = full_add(sa[0], sb[0], c);

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_w1
      always_comb sum_nxt = fa_out[0];
    end else begin : g_wn
      always_comb sum_nxt = {fa_out[0], sum[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ADD);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa        <= '0;
      sb        <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            c   <= 1'b0;
            cnt <= '0;
          end
        end
        ADD: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          c   <= fa_out[1];
          sum <= sum_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) carry_out <= fa_out[1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1; expected results
// are plain integer sums of the operands, checked when done pulses.
module tb_serial_adder;

  typedef struct {
    int r;    // a + b, including the carry bit
    int e;    // edge count at which done must be visible
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, co8, busy1, done1, co1;
  logic [7:0] sum8;
  logic [0:0] sum1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t q8[$];
  exp_t q1[$];
  int   last8 = 0, last1 = 0;
  int   bcnt8 = 0, bcnt1 = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .carry_out(co1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop on done, verify result, latency and busy length; verify hold while idle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy8 && done8) chk("busy_done_excl8", 1, 0);
      if (busy8) bcnt8++;
      if (done8) begin
        if (q8.size() == 0) chk("unexpected_done8", 1, 0);
        else begin
          exp_t e;
          e = q8.pop_front();
          chk("result8", int'({co8, sum8}), e.r);
          chk("latency8", cyc, e.e);
          chk("busy_len8", bcnt8, 8);
          last8 = e.r;
        end
        bcnt8 = 0;
      end else if (!busy8) begin
        chk("hold8", int'({co8, sum8}), last8);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (busy1 && done1) chk("busy_done_excl1", 1, 0);
      if (busy1) bcnt1++;
      if (done1) begin
        if (q1.size() == 0) chk("unexpected_done1", 1, 0);
        else begin
          exp_t e;
          e = q1.pop_front();
          chk("result1", int'({co1, sum1}), e.r);
          chk("latency1", cyc, e.e);
          chk("busy_len1", bcnt1, 1);
          last1 = e.r;
        end
        bcnt1 = 0;
      end else if (!busy1) begin
        chk("hold1", int'({co1, sum1}), last1);
      end
    end
  end

  // Returns at a negedge where dut8 is in IDLE.
  task automatic wait_idle8();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        $display("FAIL idle_timeout8 actual=busy%0b required=idle", busy8);
        $fatal(1, "dut8 never returned to idle");
      end
    end while (!(busy8 === 1'b0 && done8 === 1'b0));
  endtask

  task automatic wait_idle1();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        $display("FAIL idle_timeout1 actual=busy%0b required=idle", busy1);
        $fatal(1, "dut1 never returned to idle");
      end
    end while (!(busy1 === 1'b0 && done1 === 1'b0));
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    wait_idle8();
    a8 = x; b8 = y; start8 = 1'b1;
    e.r = int'(x) + int'(y);
    e.e = cyc + 1 + 8;
    q8.push_back(e);
    @(posedge clk);
    #1 start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic op1(input logic x, input logic y);
    exp_t e;
    wait_idle1();
    a1 = x; b1 = y; start1 = 1'b1;
    e.r = int'(x) + int'(y);
    e.e = cyc + 1 + 1;
    q1.push_back(e);
    @(posedge clk);
    #1 start1 = 1'b0;
  endtask

  initial begin
    int e0;
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    @(posedge clk);
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy8), 0);
    chk("rst_done", int'(done8), 0);
    chk("rst_sum", int'(sum8), 0);
    chk("rst_co", int'(co8), 0);

    // Directed cases
    op8(8'h5A, 8'h3C);
    op8(8'hFF, 8'h01);
    op8(8'hFF, 8'hFF);
    op8(8'h00, 8'h00);

    // start during ADD must be ignored, operands are not resampled
    op8(8'h10, 8'h20);
    repeat (2) @(posedge clk);
    #2 start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk);
    #1 start8 = 1'b0;

    // reset abandons an operation mid-flight with no done pulse
    op8(8'hAA, 8'h55);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    q8.delete();
    last8 = 0; last1 = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    bcnt8 = 0;
    @(negedge clk);
    chk("abort_busy", int'(busy8), 0);
    chk("abort_sum", int'(sum8), 0);
    chk("abort_co", int'(co8), 0);
    repeat (12) @(negedge clk);
    op8(8'hAA, 8'h55);

    // random operands with random gaps
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      op8(8'($urandom), 8'($urandom));
    end

    // start held high: accepts every WIDTH+2 edges
    wait_idle8();
    e0 = cyc + 1;
    start8 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_t e;
      logic [7:0] x, y;
      x = 8'($urandom); y = 8'($urandom);
      a8 = x; b8 = y;
      e.r = int'(x) + int'(y);
      e.e = e0 + 8;
      q8.push_back(e);
      @(posedge clk);
      #1 a8 = 8'($urandom); b8 = 8'($urandom);
      repeat (8 + 1) @(posedge clk);
      #1;
      e0 = e0 + 8 + 2;
    end
    start8 = 1'b0;

    // WIDTH=1 build: all four combinations, then back-to-back
    for (int i = 0; i < 4; i++) op1(1'(i >> 1), 1'(i));
    wait_idle1();
    e0 = cyc + 1;
    start1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      logic x, y;
      x = 1'($urandom); y = 1'($urandom);
      a1 = x; b1 = y;
      e.r = int'(x) + int'(y);
      e.e = e0 + 1;
      q1.push_back(e);
      @(posedge clk);
      #1 a1 = ~x; b1 = ~y;
      repeat (1 + 1) @(posedge clk);
      #1;
      e0 = e0 + 1 + 2;
    end
    start1 = 1'b0;

    begin
      int n = 0;
      while ((q8.size() != 0 || q1.size() != 0) && n < 200) begin
        @(negedge clk);
        n++;
      end
      repeat (4) @(negedge clk);
      chk("drain8", q8.size(), 0);
      chk("drain1", q1.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
